// File: rtl/msi_l1_cache_ctrl.sv
// Private fully associative L1 cache controller for one node of an MSI directory protocol.
// Serves CPU reads/writes, issues ReadMiss/WriteMiss/WriteBack, and answers directory commands.
module msi_l1_cache_ctrl #(
    parameter int unsigned LINES = 2,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 4
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          CpuValid,
    input  logic          CpuWrite,
    input  logic [AW-1:0] CpuAddr,
    input  logic [DW-1:0] CpuWData,
    output logic          CpuReady,
    output logic [DW-1:0] CpuRData,
    output logic          CpuHit,
    output logic          DirReqValid,
    output logic [2:0]    DirReqType,
    output logic [AW-1:0] DirReqAddr,
    output logic [DW-1:0] DirReqData,
    input  logic          DirReqReady,
    input  logic          DirRespValid,
    input  logic [DW-1:0] DirRespData,
    input  logic          DirCmdValid,
    input  logic [2:0]    DirCmdType,
    input  logic [AW-1:0] DirCmdAddr,
    output logic          DirCmdAck,
    output logic          DirCmdHasData,
    output logic [DW-1:0] DirCmdData
);

    localparam int unsigned PW = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [2:0] ST_EMPTY = 3'b000;
    localparam logic [2:0] ST_I     = 3'b001;
    localparam logic [2:0] ST_S     = 3'b010;
    localparam logic [2:0] ST_M     = 3'b011;

    localparam logic [2:0] REQ_RM   = 3'b001;
    localparam logic [2:0] REQ_WM   = 3'b010;
    localparam logic [2:0] REQ_WB   = 3'b011;

    localparam logic [2:0] CMD_FETCH     = 3'b011;
    localparam logic [2:0] CMD_FETCH_INV = 3'b100;
    localparam logic [2:0] CMD_INV       = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB_REQ, S_MISS_REQ, S_WAIT_RESP, S_COMPLETE
    } fsm_e;

    fsm_e            fsm_q, fsm_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   vic_q, vic_d;
    logic            req_wr_q, req_wr_d;
    logic [AW-1:0]   req_addr_q, req_addr_d;
    logic [DW-1:0]   req_wdata_q, req_wdata_d;

    logic [2:0]      st_q   [LINES];
    logic [2:0]      st_d   [LINES];
    logic [AW-1:0]   tag_q  [LINES];
    logic [AW-1:0]   tag_d  [LINES];
    logic [DW-1:0]   data_q [LINES];
    logic [DW-1:0]   data_d [LINES];

    logic            cpu_ready_q, cpu_ready_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic            cpu_hit_q, cpu_hit_d;
    logic            dreq_valid_q, dreq_valid_d;
    logic [2:0]      dreq_type_q, dreq_type_d;
    logic [AW-1:0]   dreq_addr_q, dreq_addr_d;
    logic [DW-1:0]   dreq_data_q, dreq_data_d;
    logic            cmd_ack_q, cmd_ack_d;
    logic            cmd_has_data_q, cmd_has_data_d;
    logic [DW-1:0]   cmd_data_q, cmd_data_d;

    logic [2:0]      st_cmd_c [LINES];
    logic            cmd_has_data_c;
    logic [DW-1:0]   cmd_data_c;
    logic            hit_c, free_c;
    logic [PW-1:0]   hit_idx_c, free_idx_c, victim_c;
    logic [2:0]      miss_type_c;

    // Directory command applied first; everything below sees the post-command line states.
    always_comb begin
        st_cmd_c       = st_q;
        cmd_has_data_c = 1'b0;
        cmd_data_c     = '0;
        if (DirCmdValid) begin
            for (int i = 0; i < int'(LINES); i++) begin
                if (tag_q[i] == DirCmdAddr && (st_q[i] == ST_S || st_q[i] == ST_M)) begin
                    case (DirCmdType)
                        CMD_FETCH: if (st_q[i] == ST_M) begin
                            cmd_has_data_c = 1'b1;
                            cmd_data_c     = data_q[i];
                            st_cmd_c[i]    = ST_S;
                        end
                        CMD_FETCH_INV: begin
                            if (st_q[i] == ST_M) begin
                                cmd_has_data_c = 1'b1;
                                cmd_data_c     = data_q[i];
                            end
                            st_cmd_c[i] = ST_I;
                        end
                        CMD_INV: st_cmd_c[i] = ST_I;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Hit search and lowest-index free line; descending scan so the lowest index wins.
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int i = int'(LINES) - 1; i >= 0; i--) begin
            if (tag_q[i] == req_addr_q && (st_cmd_c[i] == ST_S || st_cmd_c[i] == ST_M)) begin
                hit_c     = 1'b1;
                hit_idx_c = PW'(i);
            end
            if (st_cmd_c[i] == ST_EMPTY || st_cmd_c[i] == ST_I) begin
                free_c     = 1'b1;
                free_idx_c = PW'(i);
            end
        end
    end

    always_comb begin
        fsm_d          = fsm_q;
        rr_d           = rr_q;
        vic_d          = vic_q;
        req_wr_d       = req_wr_q;
        req_addr_d     = req_addr_q;
        req_wdata_d    = req_wdata_q;
        st_d           = st_cmd_c;
        tag_d          = tag_q;
        data_d         = data_q;
        cpu_ready_d    = 1'b0;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_hit_d      = cpu_hit_q;
        dreq_valid_d   = dreq_valid_q;
        dreq_type_d    = dreq_type_q;
        dreq_addr_d    = dreq_addr_q;
        dreq_data_d    = dreq_data_q;
        cmd_ack_d      = DirCmdValid;
        cmd_has_data_d = cmd_has_data_c;
        cmd_data_d     = cmd_data_c;
        victim_c       = free_c ? free_idx_c : rr_q;
        miss_type_c    = req_wr_q ? REQ_WM : REQ_RM;

        unique case (fsm_q)
            S_IDLE: if (CpuValid) begin
                req_wr_d    = CpuWrite;
                req_addr_d  = CpuAddr;
                req_wdata_d = CpuWData;
                fsm_d       = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit_c && !req_wr_q) begin
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = data_q[hit_idx_c];
                    cpu_hit_d   = 1'b1;
                    fsm_d       = S_COMPLETE;
                end else if (hit_c && st_cmd_c[hit_idx_c] == ST_M) begin
                    data_d[hit_idx_c] = req_wdata_q;
                    cpu_ready_d       = 1'b1;
                    cpu_rdata_d       = req_wdata_q;
                    cpu_hit_d         = 1'b1;
                    fsm_d             = S_COMPLETE;
                end else if (hit_c) begin
                    vic_d        = hit_idx_c;
                    dreq_valid_d = 1'b1;
                    dreq_type_d  = REQ_WM;
                    dreq_addr_d  = req_addr_q;
                    dreq_data_d  = req_wdata_q;
                    fsm_d        = S_MISS_REQ;
                end else begin
                    vic_d = victim_c;
                    if (!free_c) begin
                        rr_d = (rr_q == PW'(LINES - 1)) ? '0 : rr_q + PW'(1);
                    end
                    dreq_valid_d = 1'b1;
                    if (st_cmd_c[victim_c] == ST_M) begin
                        dreq_type_d = REQ_WB;
                        dreq_addr_d = tag_q[victim_c];
                        dreq_data_d = data_q[victim_c];
                        fsm_d       = S_WB_REQ;
                    end else begin
                        dreq_type_d = miss_type_c;
                        dreq_addr_d = req_addr_q;
                        dreq_data_d = req_wdata_q;
                        fsm_d       = S_MISS_REQ;
                    end
                end
            end
            S_WB_REQ: if (DirReqReady) begin
                st_d[vic_q] = ST_I;
                dreq_type_d = miss_type_c;
                dreq_addr_d = req_addr_q;
                dreq_data_d = req_wdata_q;
                fsm_d       = S_MISS_REQ;
            end
            S_MISS_REQ: if (DirReqReady) begin
                dreq_valid_d = 1'b0;
                fsm_d        = S_WAIT_RESP;
            end
            S_WAIT_RESP: if (DirRespValid) begin
                tag_d[vic_q]  = req_addr_q;
                st_d[vic_q]   = req_wr_q ? ST_M : ST_S;
                data_d[vic_q] = req_wr_q ? req_wdata_q : DirRespData;
                cpu_ready_d   = 1'b1;
                cpu_rdata_d   = req_wr_q ? req_wdata_q : DirRespData;
                cpu_hit_d     = 1'b0;
                fsm_d         = S_COMPLETE;
            end
            S_COMPLETE: fsm_d = S_IDLE;
            default:    fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm_q          <= S_IDLE;
            rr_q           <= '0;
            vic_q          <= '0;
            req_wr_q       <= 1'b0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            st_q           <= '{default: ST_EMPTY};
            tag_q          <= '{default: '0};
            data_q         <= '{default: '0};
            cpu_ready_q    <= 1'b0;
            cpu_rdata_q    <= '0;
            cpu_hit_q      <= 1'b0;
            dreq_valid_q   <= 1'b0;
            dreq_type_q    <= '0;
            dreq_addr_q    <= '0;
            dreq_data_q    <= '0;
            cmd_ack_q      <= 1'b0;
            cmd_has_data_q <= 1'b0;
            cmd_data_q     <= '0;
        end else begin
            fsm_q          <= fsm_d;
            rr_q           <= rr_d;
            vic_q          <= vic_d;
            req_wr_q       <= req_wr_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            st_q           <= st_d;
            tag_q          <= tag_d;
            data_q         <= data_d;
            cpu_ready_q    <= cpu_ready_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_hit_q      <= cpu_hit_d;
            dreq_valid_q   <= dreq_valid_d;
            dreq_type_q    <= dreq_type_d;
            dreq_addr_q    <= dreq_addr_d;
            dreq_data_q    <= dreq_data_d;
            cmd_ack_q      <= cmd_ack_d;
            cmd_has_data_q <= cmd_has_data_d;
            cmd_data_q     <= cmd_data_d;
        end
    end

    assign CpuReady      = cpu_ready_q;
    assign CpuRData      = cpu_rdata_q;
    assign CpuHit        = cpu_hit_q;
    assign DirReqValid   = dreq_valid_q;
    assign DirReqType    = dreq_type_q;
    assign DirReqAddr    = dreq_addr_q;
    assign DirReqData    = dreq_data_q;
    assign DirCmdAck     = cmd_ack_q;
    assign DirCmdHasData = cmd_has_data_q;
    assign DirCmdData    = cmd_data_q;

endmodule

// File: tb/tb_msi_l1_cache_ctrl.sv
// Self-checking bench for msi_l1_cache_ctrl: default 2-line instance plus a 4-line/8-bit/16-bit sweep instance.
module tb_msi_l1_cache_ctrl;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;
    logic Reset_n;

    logic       cpu_valid, cpu_write, cpu_ready, cpu_hit;
    logic [3:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       dir_req_valid, dir_req_ready, dir_resp_valid;
    logic [2:0] dir_req_type;
    logic [3:0] dir_req_addr, dir_req_data, dir_resp_data;
    logic       dir_cmd_valid, dir_cmd_ack, dir_cmd_has_data;
    logic [2:0] dir_cmd_type;
    logic [3:0] dir_cmd_addr, dir_cmd_data;

    logic        cpu_valid2, cpu_write2, cpu_ready2, cpu_hit2;
    logic [7:0]  cpu_addr2;
    logic [15:0] cpu_wdata2, cpu_rdata2;
    logic        dir_req_valid2, dir_req_ready2, dir_resp_valid2;
    logic [2:0]  dir_req_type2;
    logic [7:0]  dir_req_addr2;
    logic [15:0] dir_req_data2, dir_resp_data2;
    logic        dir_cmd_valid2, dir_cmd_ack2, dir_cmd_has_data2;
    logic [2:0]  dir_cmd_type2;
    logic [7:0]  dir_cmd_addr2;
    logic [15:0] dir_cmd_data2;

    msi_l1_cache_ctrl dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .CpuValid(cpu_valid), .CpuWrite(cpu_write), .CpuAddr(cpu_addr), .CpuWData(cpu_wdata),
        .CpuReady(cpu_ready), .CpuRData(cpu_rdata), .CpuHit(cpu_hit),
        .DirReqValid(dir_req_valid), .DirReqType(dir_req_type), .DirReqAddr(dir_req_addr),
        .DirReqData(dir_req_data), .DirReqReady(dir_req_ready),
        .DirRespValid(dir_resp_valid), .DirRespData(dir_resp_data),
        .DirCmdValid(dir_cmd_valid), .DirCmdType(dir_cmd_type), .DirCmdAddr(dir_cmd_addr),
        .DirCmdAck(dir_cmd_ack), .DirCmdHasData(dir_cmd_has_data), .DirCmdData(dir_cmd_data)
    );

    msi_l1_cache_ctrl #(.LINES(4), .AW(8), .DW(16)) dut2 (
        .Clock(Clock), .Reset_n(Reset_n),
        .CpuValid(cpu_valid2), .CpuWrite(cpu_write2), .CpuAddr(cpu_addr2), .CpuWData(cpu_wdata2),
        .CpuReady(cpu_ready2), .CpuRData(cpu_rdata2), .CpuHit(cpu_hit2),
        .DirReqValid(dir_req_valid2), .DirReqType(dir_req_type2), .DirReqAddr(dir_req_addr2),
        .DirReqData(dir_req_data2), .DirReqReady(dir_req_ready2),
        .DirRespValid(dir_resp_valid2), .DirRespData(dir_resp_data2),
        .DirCmdValid(dir_cmd_valid2), .DirCmdType(dir_cmd_type2), .DirCmdAddr(dir_cmd_addr2),
        .DirCmdAck(dir_cmd_ack2), .DirCmdHasData(dir_cmd_has_data2), .DirCmdData(dir_cmd_data2)
    );

    typedef struct packed {
        logic [15:0] rdata;
        logic        hit;
        logic        chk_rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [2:0] obs_type [4];
    logic [3:0] obs_addr [4];
    logic [3:0] obs_data [4];
    int         obs_nreq, obs_lat;
    logic       obs_ready, obs_hit;
    logic [3:0] obs_rdata;

    logic [2:0]  obs2_type;
    logic [7:0]  obs2_addr;
    int          obs2_nreq;
    logic        obs2_ready, obs2_hit;
    logic [15:0] obs2_rdata;

    // Processor + directory driver for the default instance; records what the DUT did.
    task automatic run_access(input logic wr, input logic [3:0] a, input logic [3:0] wd,
                              input logic [3:0] rd, input int req_wait, input int cmd_at,
                              input logic [2:0] ctype, input logic [3:0] caddr);
        int cnt = 0;
        bit resp_pend = 0;
        obs_nreq = 0; obs_ready = 1'b0; obs_lat = -1; obs_hit = 1'bx; obs_rdata = 'x;
        cpu_valid = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
        for (int cyc = 1; cyc <= 60 && !obs_ready; cyc++) begin
            @(posedge Clock); #1;
            dir_cmd_valid = 1'b0;
            dir_resp_valid = 1'b0;
            if (dir_req_ready) begin
                dir_req_ready = 1'b0;
                if (obs_type[obs_nreq - 1] != 3'b011) resp_pend = 1;
            end
            if (cyc == cmd_at) begin
                dir_cmd_valid = 1'b1; dir_cmd_type = ctype; dir_cmd_addr = caddr;
            end
            if (resp_pend) begin
                dir_resp_valid = 1'b1; dir_resp_data = rd; resp_pend = 0;
            end else if (dir_req_valid) begin
                if (cnt >= req_wait) begin
                    dir_req_ready = 1'b1;
                    if (obs_nreq < 4) begin
                        obs_type[obs_nreq] = dir_req_type;
                        obs_addr[obs_nreq] = dir_req_addr;
                        obs_data[obs_nreq] = dir_req_data;
                    end
                    obs_nreq++;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
            if (cpu_ready) begin
                obs_ready = 1'b1; obs_rdata = cpu_rdata; obs_hit = cpu_hit; obs_lat = cyc;
                cpu_valid = 1'b0;
            end
        end
        cpu_valid = 1'b0; dir_req_ready = 1'b0; dir_resp_valid = 1'b0; dir_cmd_valid = 1'b0;
        @(posedge Clock); #1;
    endtask

    // Same driver for the sweep instance, with immediate request acceptance.
    task automatic run_access2(input logic [7:0] a, input logic [15:0] rd);
        bit resp_pend = 0;
        obs2_nreq = 0; obs2_ready = 1'b0; obs2_type = '0; obs2_addr = '0;
        cpu_valid2 = 1'b1; cpu_write2 = 1'b0; cpu_addr2 = a; cpu_wdata2 = '0;
        for (int cyc = 1; cyc <= 40 && !obs2_ready; cyc++) begin
            @(posedge Clock); #1;
            dir_resp_valid2 = 1'b0;
            if (dir_req_ready2) begin
                dir_req_ready2 = 1'b0;
                if (obs2_type != 3'b011) resp_pend = 1;
            end
            if (resp_pend) begin
                dir_resp_valid2 = 1'b1; dir_resp_data2 = rd; resp_pend = 0;
            end else if (dir_req_valid2) begin
                dir_req_ready2 = 1'b1;
                obs2_type = dir_req_type2; obs2_addr = dir_req_addr2;
                obs2_nreq++;
            end
            if (cpu_ready2) begin
                obs2_ready = 1'b1; obs2_rdata = cpu_rdata2; obs2_hit = cpu_hit2;
                cpu_valid2 = 1'b0;
            end
        end
        cpu_valid2 = 1'b0; dir_req_ready2 = 1'b0; dir_resp_valid2 = 1'b0;
        @(posedge Clock); #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({cpu_ready, cpu_hit, dir_req_valid, dir_cmd_ack, dir_cmd_has_data} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {cpu_ready, cpu_hit, dir_req_valid, dir_cmd_ack, dir_cmd_has_data});
        end
        n_cmp++;
        if ({cpu_rdata, dir_req_type, dir_req_addr, dir_req_data, dir_cmd_data} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0",
                     {cpu_rdata, dir_req_type, dir_req_addr, dir_req_data, dir_cmd_data});
        end
        n_cmp++;
        if ({cpu_ready2, dir_req_valid2, dir_cmd_ack2, cpu_rdata2} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_sweep: got %h, required 0",
                     {cpu_ready2, dir_req_valid2, dir_cmd_ack2, cpu_rdata2});
        end
    endtask

    task automatic test_read_miss_hit();
        exp_t e;
        sb_q.push_back('{rdata: 16'h6, hit: 1'b0, chk_rdata: 1'b1});
        run_access(1'b0, 4'b0111, 4'b0, 4'b0110, 1, -1, 3'b0, 4'b0);
        n_cmp++;
        if (obs_nreq !== 1 || obs_type[0] !== 3'b001 || obs_addr[0] !== 4'b0111 || obs_lat !== 5) begin
            n_fail++;
            $display("FAIL read_miss_req: nreq=%0d type=%b addr=%b lat=%0d, required 1/001/0111/5",
                     obs_nreq, obs_type[0], obs_addr[0], obs_lat);
        end
        e = sb_q.pop_front(); n_cmp++;
        if (obs_ready !== 1'b1 || obs_hit !== e.hit || obs_rdata !== 4'(e.rdata)) begin
            n_fail++;
            $display("FAIL read_miss_resp: ready=%b hit=%b rdata=%h, required 1/%b/%h",
                     obs_ready, obs_hit, obs_rdata, e.hit, 4'(e.rdata));
        end
        sb_q.push_back('{rdata: 16'h6, hit: 1'b1, chk_rdata: 1'b1});
        run_access(1'b0, 4'b0111, 4'b0, 4'b0, 1, -1, 3'b0, 4'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (obs_ready !== 1'b1 || obs_nreq !== 0 || obs_lat !== 2 || obs_hit !== e.hit || obs_rdata !== 4'(e.rdata)) begin
            n_fail++;
            $display("FAIL read_hit: ready=%b nreq=%0d lat=%0d hit=%b rdata=%h, required 1/0/2/%b/%h",
                     obs_ready, obs_nreq, obs_lat, obs_hit, obs_rdata, e.hit, 4'(e.rdata));
        end
    endtask

    task automatic test_write_upgrade();
        exp_t e;
        run_access(1'b0, 4'b0100, 4'b0, 4'b1010, 0, -1, 3'b0, 4'b0);
        sb_q.push_back('{rdata: 16'h0, hit: 1'b0, chk_rdata: 1'b0});
        run_access(1'b1, 4'b0100, 4'b0011, 4'b1111, 1, -1, 3'b0, 4'b0);
        n_cmp++;
        if (obs_nreq !== 1 || obs_type[0] !== 3'b010 || obs_addr[0] !== 4'b0100) begin
            n_fail++;
            $display("FAIL upgrade_req: nreq=%0d type=%b addr=%b, required 1/010/0100",
                     obs_nreq, obs_type[0], obs_addr[0]);
        end
        e = sb_q.pop_front(); n_cmp++;
        if (obs_ready !== 1'b1 || obs_hit !== e.hit) begin
            n_fail++;
            $display("FAIL upgrade_resp: ready=%b hit=%b, required 1/%b", obs_ready, obs_hit, e.hit);
        end
        sb_q.push_back('{rdata: 16'h3, hit: 1'b1, chk_rdata: 1'b1});
        run_access(1'b0, 4'b0100, 4'b0, 4'b0, 0, -1, 3'b0, 4'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (obs_ready !== 1'b1 || obs_hit !== e.hit || obs_rdata !== 4'(e.rdata)) begin
            n_fail++;
            $display("FAIL upgrade_readback: ready=%b hit=%b rdata=%h, required 1/%b/%h",
                     obs_ready, obs_hit, obs_rdata, e.hit, 4'(e.rdata));
        end
    endtask

    task automatic test_eviction();
        exp_t e;
        run_access(1'b1, 4'b0111, 4'b0110, 4'b0, 0, -1, 3'b0, 4'b0);
        sb_q.push_back('{rdata: 16'h1, hit: 1'b0, chk_rdata: 1'b1});
        run_access(1'b0, 4'b1000, 4'b0, 4'b0001, 1, -1, 3'b0, 4'b0);
        n_cmp++;
        if (obs_nreq !== 2 || obs_type[0] !== 3'b011 || obs_addr[0] !== 4'b0111 || obs_data[0] !== 4'b0110
            || obs_type[1] !== 3'b001 || obs_addr[1] !== 4'b1000) begin
            n_fail++;
            $display("FAIL evict_wb: nreq=%0d wb=%b/%b/%b miss=%b/%b, required 2 011/0111/0110 001/1000",
                     obs_nreq, obs_type[0], obs_addr[0], obs_data[0], obs_type[1], obs_addr[1]);
        end
        e = sb_q.pop_front(); n_cmp++;
        if (obs_ready !== 1'b1 || obs_hit !== e.hit || obs_rdata !== 4'(e.rdata)) begin
            n_fail++;
            $display("FAIL evict_resp: ready=%b hit=%b rdata=%h, required 1/%b/%h",
                     obs_ready, obs_hit, obs_rdata, e.hit, 4'(e.rdata));
        end
        // The pointer moved to line 1, which holds 0100 in M with 0011.
        sb_q.push_back('{rdata: 16'h2, hit: 1'b0, chk_rdata: 1'b1});
        run_access(1'b0, 4'b1001, 4'b0, 4'b0010, 0, -1, 3'b0, 4'b0);
        n_cmp++;
        if (obs_nreq !== 2 || obs_type[0] !== 3'b011 || obs_addr[0] !== 4'b0100 || obs_data[0] !== 4'b0011
            || obs_type[1] !== 3'b001 || obs_addr[1] !== 4'b1001) begin
            n_fail++;
            $display("FAIL evict_ptr: nreq=%0d wb=%b/%b/%b miss=%b/%b, required 2 011/0100/0011 001/1001",
                     obs_nreq, obs_type[0], obs_addr[0], obs_data[0], obs_type[1], obs_addr[1]);
        end
        e = sb_q.pop_front(); n_cmp++;
        if (obs_ready !== 1'b1 || obs_hit !== e.hit || obs_rdata !== 4'(e.rdata)) begin
            n_fail++;
            $display("FAIL evict_ptr_resp: ready=%b hit=%b rdata=%h, required 1/%b/%h",
                     obs_ready, obs_hit, obs_rdata, e.hit, 4'(e.rdata));
        end
    endtask

    task automatic test_dir_commands();
        run_access(1'b1, 4'b0111, 4'b0110, 4'b0, 0, -1, 3'b0, 4'b0);
        dir_cmd_valid = 1'b1; dir_cmd_type = 3'b100; dir_cmd_addr = 4'b0111;
        @(posedge Clock); #1; dir_cmd_valid = 1'b0;
        n_cmp++;
        if (dir_cmd_ack !== 1'b1 || dir_cmd_has_data !== 1'b1 || dir_cmd_data !== 4'b0110) begin
            n_fail++;
            $display("FAIL fetch_inv: ack=%b has=%b data=%b, required 1/1/0110",
                     dir_cmd_ack, dir_cmd_has_data, dir_cmd_data);
        end
        @(posedge Clock); #1;
        n_cmp++;
        if (dir_cmd_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_pulse: ack=%b, required 0", dir_cmd_ack);
        end
        dir_cmd_valid = 1'b1; dir_cmd_type = 3'b101; dir_cmd_addr = 4'b0101;
        @(posedge Clock); #1; dir_cmd_valid = 1'b0;
        n_cmp++;
        if (dir_cmd_ack !== 1'b1 || dir_cmd_has_data !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_absent: ack=%b has=%b, required 1/0", dir_cmd_ack, dir_cmd_has_data);
        end
        // Line 0 is now I: a read of 0111 misses and reuses it without a write-back.
        run_access(1'b0, 4'b0111, 4'b0, 4'b1100, 0, -1, 3'b0, 4'b0);
        n_cmp++;
        if (obs_nreq !== 1 || obs_type[0] !== 3'b001 || obs_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL after_fetch_inv: nreq=%0d type=%b hit=%b, required 1/001/0",
                     obs_nreq, obs_type[0], obs_hit);
        end
        run_access(1'b1, 4'b1001, 4'b0101, 4'b0, 0, -1, 3'b0, 4'b0);
        dir_cmd_valid = 1'b1; dir_cmd_type = 3'b011; dir_cmd_addr = 4'b1001;
        @(posedge Clock); #1; dir_cmd_valid = 1'b0;
        n_cmp++;
        if (dir_cmd_ack !== 1'b1 || dir_cmd_has_data !== 1'b1 || dir_cmd_data !== 4'b0101) begin
            n_fail++;
            $display("FAIL fetch: ack=%b has=%b data=%b, required 1/1/0101",
                     dir_cmd_ack, dir_cmd_has_data, dir_cmd_data);
        end
        run_access(1'b1, 4'b1001, 4'b0110, 4'b0, 0, -1, 3'b0, 4'b0);
        n_cmp++;
        if (obs_nreq !== 1 || obs_type[0] !== 3'b010 || obs_addr[0] !== 4'b1001) begin
            n_fail++;
            $display("FAIL fetch_to_s: nreq=%0d type=%b addr=%b, required 1/010/1001",
                     obs_nreq, obs_type[0], obs_addr[0]);
        end
    endtask

    task automatic test_cmd_collision();
        exp_t e;
        // Invalidate arrives while the read of 0111 (line S) is in LOOKUP.
        sb_q.push_back('{rdata: 16'hd, hit: 1'b0, chk_rdata: 1'b1});
        run_access(1'b0, 4'b0111, 4'b0, 4'b1101, 0, 1, 3'b101, 4'b0111);
        n_cmp++;
        if (obs_nreq !== 1 || obs_type[0] !== 3'b001 || obs_addr[0] !== 4'b0111) begin
            n_fail++;
            $display("FAIL collision_req: nreq=%0d type=%b addr=%b, required 1/001/0111",
                     obs_nreq, obs_type[0], obs_addr[0]);
        end
        e = sb_q.pop_front(); n_cmp++;
        if (obs_ready !== 1'b1 || obs_hit !== e.hit || obs_rdata !== 4'(e.rdata)) begin
            n_fail++;
            $display("FAIL collision_resp: ready=%b hit=%b rdata=%h, required 1/%b/%h",
                     obs_ready, obs_hit, obs_rdata, e.hit, 4'(e.rdata));
        end
    endtask

    task automatic test_reset_mid_miss();
        bit accepted = 0;
        bit saw_ready = 0;
        cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 4'b0011;
        for (int cyc = 0; cyc < 20 && !accepted; cyc++) begin
            @(posedge Clock); #1;
            if (dir_req_ready) begin
                dir_req_ready = 1'b0; accepted = 1;
            end else if (dir_req_valid) begin
                dir_req_ready = 1'b1;
            end
        end
        n_cmp++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL mid_miss_timeout: accepted=%0b, required 1", accepted);
        end
        Reset_n = 1'b0; cpu_valid = 1'b0; #1;
        n_cmp++;
        if ({cpu_ready, cpu_hit, dir_req_valid, cpu_rdata, dir_req_type, dir_req_addr} !== 15'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %h, required 0",
                     {cpu_ready, cpu_hit, dir_req_valid, cpu_rdata, dir_req_type, dir_req_addr});
        end
        dir_resp_valid = 1'b1; dir_resp_data = 4'b1111;
        @(posedge Clock); #1; dir_resp_valid = 1'b0;
        @(posedge Clock); #1; Reset_n = 1'b1;
        dir_resp_valid = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge Clock); #1; dir_resp_valid = 1'b0;
            if (cpu_ready) saw_ready = 1;
        end
        n_cmp++;
        if (saw_ready || dir_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_req: cpu_ready_seen=%0b req_valid=%b, required 0/0", saw_ready, dir_req_valid);
        end
        run_access(1'b0, 4'b0111, 4'b0, 4'b1000, 0, -1, 3'b0, 4'b0);
        n_cmp++;
        if (obs_nreq !== 1 || obs_type[0] !== 3'b001 || obs_hit !== 1'b0 || obs_rdata !== 4'b1000) begin
            n_fail++;
            $display("FAIL lines_cleared: nreq=%0d type=%b hit=%b rdata=%b, required 1/001/0/1000",
                     obs_nreq, obs_type[0], obs_hit, obs_rdata);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] addrs [12];
        bit         hits  [12];
        exp_t       e;
        addrs = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h10, 8'h12, 8'h11};
        hits  = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0};
        for (int i = 0; i < 12; i++) begin
            sb_q.push_back('{rdata: {8'hA5, addrs[i]}, hit: hits[i], chk_rdata: 1'b1});
            run_access2(addrs[i], {8'hA5, addrs[i]});
            e = sb_q.pop_front(); n_cmp++;
            if (obs2_ready !== 1'b1 || obs2_hit !== e.hit || obs2_rdata !== e.rdata
                || obs2_nreq !== (e.hit ? 0 : 1) || (!e.hit && (obs2_type !== 3'b001 || obs2_addr !== addrs[i]))) begin
                n_fail++;
                $display("FAIL sweep[%0d]: ready=%b hit=%b rdata=%h nreq=%0d type=%b addr=%h, required hit=%b rdata=%h",
                         i, obs2_ready, obs2_hit, obs2_rdata, obs2_nreq, obs2_type, obs2_addr, e.hit, e.rdata);
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        cpu_valid = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
        dir_req_ready = 0; dir_resp_valid = 0; dir_resp_data = '0;
        dir_cmd_valid = 0; dir_cmd_type = '0; dir_cmd_addr = '0;
        cpu_valid2 = 0; cpu_write2 = 0; cpu_addr2 = '0; cpu_wdata2 = '0;
        dir_req_ready2 = 0; dir_resp_valid2 = 0; dir_resp_data2 = '0;
        dir_cmd_valid2 = 0; dir_cmd_type2 = '0; dir_cmd_addr2 = '0;
        repeat (3) @(posedge Clock);
        #1; Reset_n = 1'b1;
        @(posedge Clock); #1;
        test_reset();
        test_read_miss_hit();
        test_write_upgrade();
        test_eviction();
        test_dir_commands();
        test_cmd_collision();
        test_reset_mid_miss();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/msi_l1_cache_ctrl.md
# msi_l1_cache_ctrl

Parametrised private L1 cache controller for one processor node of the MSI directory-coherence system. Holds `LINES` fully associative lines with 3-bit MSI state, serves processor reads and writes, and issues ReadMiss, WriteMiss and WriteBack requests to the directory over valid/ready handshakes. It also answers directory Fetch, FetchInvalidate and Invalidate commands. It generalises the fixed two-line, negedge-driven per-processor cache to arbitrary depth and width, with reset, real replacement and eviction.

## Interface
- `LINES`, default 2: number of cache lines, ≥1; pointer width `$clog2(LINES)`, minimum 1.
- `AW`, default 4: address/tag width.
- `DW`, default 4: data width (one word per line).
- `Clock` in 1: single clock; all state changes on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `CpuValid` in 1: processor request valid; held until `CpuReady`.
- `CpuWrite` in 1: 1 = write, 0 = read.
- `CpuAddr` in AW: request address.
- `CpuWData` in DW: write data.
- `CpuReady` out 1: one-cycle completion pulse.
- `CpuRData` out DW: read data, valid with `CpuReady`.
- `CpuHit` out 1: 1 if the request hit without a directory transaction, valid with `CpuReady`.
- `DirReqValid` out 1: directory request valid.
- `DirReqType` out 3: 001 ReadMiss, 010 WriteMiss, 011 WriteBack.
- `DirReqAddr` out AW: request address.
- `DirReqData` out DW: write-back data.
- `DirReqReady` in 1: directory accepts the request.
- `DirRespValid` in 1: fill or grant response.
- `DirRespData` in DW: fill data; ignored for upgrade grants.
- `DirCmdValid` in 1: directory command, single-cycle pulse.
- `DirCmdType` in 3: 011 Fetch, 100 FetchInvalidate, 101 Invalidate.
- `DirCmdAddr` in AW: command address.
- `DirCmdAck` out 1: one-cycle acknowledge.
- `DirCmdHasData` out 1: line was M; `DirCmdData` is valid.
- `DirCmdData` out DW: line data returned.

## Operation
- Line state encoding: 000 empty, 001 I, 010 S, 011 M. Reset sets all lines to empty, tag 0 and data 0.
- A lookup hits when the tag matches and the state is S or M. A tag match in state I or empty is a miss.
- FSM states: IDLE, LOOKUP, WB_REQ, MISS_REQ, WAIT_RESP, COMPLETE.
- IDLE: on `CpuValid`, latch the request and go to LOOKUP.
- LOOKUP, read hit: go to COMPLETE with `CpuHit` = 1.
- LOOKUP, write hit in M: update data and go to COMPLETE with `CpuHit` = 1.
- LOOKUP, write hit in S: go to MISS_REQ with type 010 (upgrade). Victim = the matching line.
- LOOKUP, miss, victim selection:
  - First choice: the lowest-index line in empty or I.
  - Otherwise: the line at the round-robin pointer, which then increments modulo `LINES`.
  - If the victim is in M, go to WB_REQ. Otherwise go to MISS_REQ (read → 001, write → 010).
- WB_REQ: drive type 011 with the victim tag and data. On `DirReqReady`, set the victim to I and go to MISS_REQ.
- MISS_REQ: hold `DirReqValid` and all request fields stable until `DirReqReady`, then go to WAIT_RESP.
- WAIT_RESP: on `DirRespValid`, install the line and go to COMPLETE with `CpuHit` = 0.
  - Read fill: state S, data = `DirRespData`.
  - Write: state M, data = `CpuWData`.
- COMPLETE: pulse `CpuReady`, then return to IDLE.
- Directory commands are serviced in every FSM state, in the cycle of `DirCmdValid`. `DirCmdAck` is asserted the following cycle.
  - Fetch on M: return data and set the line to S.
  - FetchInvalidate on M: return data and set the line to I.
  - Invalidate on S: set the line to I.
  - Any command to an absent, I or empty line: ack with `DirCmdHasData` = 0 and no state change.
- Simultaneous command and CPU update to the same line in the same cycle: the command is applied first; the CPU update then acts on the post-command state.
  - In LOOKUP, the hit/miss decision is re-evaluated against the post-command state.
  - An invalidated line being upgraded from S causes a fall-through to a full WriteMiss (the request type is already 010, so only the victim state changes).

## Timing
- Reset values of all outputs: 0. FSM = IDLE; round-robin pointer = 0.
- Hit latency: `CpuValid` seen in IDLE at cycle 0; `CpuReady` at cycle 2.
- Miss latency: 3 cycles plus the request wait plus the response wait. A write-back adds ≥1 cycle.
- `DirReqValid` is registered and never drops before `DirReqReady`.
- `DirRespValid` outside WAIT_RESP is ignored.
- `Reset_n` low at any point, including mid-miss, immediately clears all lines, the FSM and the outputs. A pending request is dropped with no `CpuReady`.

## Test plan
- Read miss then read hit:
  - After reset, read 0111; accept the request after 1 cycle; respond with 0110 → `CpuRData` 0110, `CpuHit` 0, line S.
  - Re-read 0111 → `CpuReady` 2 cycles after valid, `CpuHit` 1.
- Write upgrade: with 0100 in S, write 0011 → type 010 at 0100; after the response, line M with data 0011, `CpuHit` 0.
- Eviction write-back (`LINES` = 2, both full, the pointer line in M with 0111/0110): read 1000 → WB 011/0111/0110 first, then 001/1000; the pointer advances.
- Directory commands:
  - FetchInvalidate at 0111 while M/0110 → next-cycle ack, `DirCmdHasData` 1, data 0110, line I.
  - Invalidate at an absent address → ack, `DirCmdHasData` 0, no state change.
- Reset mid-miss: drop `Reset_n` during WAIT_RESP → outputs 0, all lines empty, no `CpuReady`. A later `DirRespValid` is ignored.
- Sweep `LINES` = 4, `AW` = 8, `DW` = 16: four distinct read misses fill empty lines 0–3 in order; a fifth evicts line 0.
